trng_sram_fifo_ctrl: RTL

//  - Ring-buffer FIFO controller between the TRNG Wishbone wrapper and the 2 KB dual-port SRAM macro.
//  - Accepts 32-bit TRNG words and writes them through SRAM port B (RW); serves consumer pops through port A (R).
//  - Lets firmware drain a pool of pre-harvested entropy faster than the TRNG produces it.

---
 rtl/trng_fifo_pkg.sv | 14 +
 rtl/trng_rep_check.sv | 43 ++++
 rtl/trng_sram_fifo_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/trng_fifo_pkg.sv
// Shared types and constants for the TRNG SRAM ring-buffer FIFO controller.
package trng_fifo_pkg;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_REQ  = 2'd1,
        RD_CAP  = 2'd2
    } rd_state_t;

    localparam int unsigned SRAM_DEPTH_MAX = 512;
    localparam logic [3:0]  MASK_ALL       = 4'hF;
    localparam logic        CSB_IDLE       = 1'b1;

endpackage

// File: rtl/trng_rep_check.sv
// Repetition test: flags an accepted TRNG word identical to the previous accepted word.
// Sticky error flag clears only on reset.
module trng_rep_check #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              accept_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              repeat_o,
    output logic              rep_err_o
);

    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_vld_q, prev_vld_d;
    logic              err_q, err_d;

    assign repeat_o  = accept_i & prev_vld_q & (data_i == prev_q);
    assign rep_err_o = err_q;

    always_comb begin
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        err_d      = err_q | repeat_o;
        if (accept_i) begin
            prev_d     = data_i;
            prev_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: rtl/trng_sram_fifo_ctrl.sv
// Ring-buffer FIFO controller between the TRNG wrapper and a dual-port SRAM macro.
// Define TRNG_REPEAT_CHECK_EN to drop repeated words and raise a sticky rep_err_o.
module trng_sram_fifo_ctrl
    import trng_fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              trng_valid_i,
    input  logic [DATA_W-1:0] trng_data_i,
    output logic              trng_ready_o,
    input  logic              pop_i,
    output logic              pop_valid_o,
    output logic [DATA_W-1:0] pop_data_o,
    output logic [ADDR_W:0]   level_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              rep_err_o,
    output logic              sram_csb_b,
    output logic              sram_web_b,
    output logic [3:0]        sram_mask_b,
    output logic [ADDR_W-1:0] sram_addr_b,
    output logic [DATA_W-1:0] sram_din_b,
    output logic              sram_csb_a,
    output logic [ADDR_W-1:0] sram_addr_a,
    input  logic [DATA_W-1:0] sram_dout_a
);

    localparam int unsigned DepthEff = (DEPTH > SRAM_DEPTH_MAX) ? SRAM_DEPTH_MAX : DEPTH;
    localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DepthEff - 1);
    localparam logic [ADDR_W:0]   DepthL  = (ADDR_W + 1)'(DepthEff);

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              full_q, full_d, empty_q, empty_d, ready_q, ready_d;
    logic              csb_a_q, csb_a_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic              pop_valid_q, pop_valid_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic              csb_b_q, csb_b_d, web_b_q, web_b_d;
    logic [3:0]        mask_b_q, mask_b_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic [DATA_W-1:0] din_b_q, din_b_d;

    logic push_acc, push_store, pop_acc;

    assign push_acc = trng_valid_i & ready_q;
    assign pop_acc  = (state_q == RD_IDLE) & pop_i & ~empty_q;

`ifdef TRNG_REPEAT_CHECK_EN
    logic is_repeat;

    trng_rep_check #(
        .DATA_W (DATA_W)
    ) u_rep_check (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .accept_i  (push_acc),
        .data_i    (trng_data_i),
        .repeat_o  (is_repeat),
        .rep_err_o (rep_err_o)
    );

    // A repeated word is still accepted (ready stays high) but never stored.
    assign push_store = push_acc & ~is_repeat;
`else
    assign push_store = push_acc;
    assign rep_err_o  = 1'b0;
`endif

    // Write path and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        csb_b_d  = CSB_IDLE;
        web_b_d  = 1'b1;
        mask_b_d = '0;
        addr_b_d = addr_b_q;
        din_b_d  = din_b_q;
        if (push_store) begin
            csb_b_d  = 1'b0;
            web_b_d  = 1'b0;
            mask_b_d = MASK_ALL;
            addr_b_d = wr_ptr_q;
            din_b_d  = trng_data_i;
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        level_d = level_q;
        case ({push_store, pop_acc})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        full_d  = (level_d == DepthL);
        empty_d = (level_d == '0);
        ready_d = ~full_d;
    end

    // Read FSM: state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= RD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RD_IDLE: if (pop_acc) state_d = RD_REQ;
            RD_REQ:  state_d = RD_CAP;
            RD_CAP:  state_d = RD_IDLE;
            default: state_d = RD_IDLE;
        endcase
    end

    // Read FSM: registered outputs; csb_a goes low for the RD_REQ cycle
    always_comb begin
        csb_a_d     = CSB_IDLE;
        addr_a_d    = addr_a_q;
        rd_ptr_d    = rd_ptr_q;
        pop_valid_d = 1'b0;
        pop_data_d  = pop_data_q;
        if (pop_acc) begin
            csb_a_d  = 1'b0;
            addr_a_d = rd_ptr_q;
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (state_q == RD_CAP) begin
            pop_data_d  = sram_dout_a;
            pop_valid_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            ready_q     <= 1'b1;
            csb_a_q     <= CSB_IDLE;
            addr_a_q    <= '0;
            pop_valid_q <= 1'b0;
            pop_data_q  <= '0;
            csb_b_q     <= CSB_IDLE;
            web_b_q     <= 1'b1;
            mask_b_q    <= '0;
            addr_b_q    <= '0;
            din_b_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            ready_q     <= ready_d;
            csb_a_q     <= csb_a_d;
            addr_a_q    <= addr_a_d;
            pop_valid_q <= pop_valid_d;
            pop_data_q  <= pop_data_d;
            csb_b_q     <= csb_b_d;
            web_b_q     <= web_b_d;
            mask_b_q    <= mask_b_d;
            addr_b_q    <= addr_b_d;
            din_b_q     <= din_b_d;
        end
    end

    assign trng_ready_o = ready_q;
    assign pop_valid_o  = pop_valid_q;
    assign pop_data_o   = pop_data_q;
    assign level_o      = level_q;
    assign full_o       = full_q;
    assign empty_o      = empty_q;
    assign sram_csb_b   = csb_b_q;
    assign sram_web_b   = web_b_q;
    assign sram_mask_b  = mask_b_q;
    assign sram_addr_b  = addr_b_q;
    assign sram_din_b   = din_b_q;
    assign sram_csb_a   = csb_a_q;
    assign sram_addr_a  = addr_a_q;

endmodule
